// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one parity UART transmitter between N byte requesters.
// Frames are timed by an internal down-counter since the transmitter has no done output.
module uart_tx_scheduler #(
  parameter int unsigned N            = 4,
  parameter int unsigned FRAME_CYCLES = 11,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic [7:0]           tx_din,
  output logic                 tx_start,
  output logic                 tx_stop,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_STOP,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [7:0]      din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Search upward from last+1 so the most recently served requester ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last_q) + i) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    din_d         = din_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_valid[grant_q]) begin
          din_d   = req_data[{grant_q, 3'b000} +: 8];
          last_d  = grant_q;
          cnt_d   = CW'(FRAME_CYCLES - 1);
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (cnt_q == '0) state_d = S_STOP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_STOP: begin
        frame_count_d = frame_count_q + 16'd1;
        if (GAP_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_q        <= IW'(N - 1);
      grant_q       <= '0;
      din_q         <= '0;
      cnt_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      din_q         <= din_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_GRANT) req_ready[grant_q] = 1'b1;
  end

  assign tx_din      = din_q;
  assign tx_start    = (state_q != S_SEND);
  assign tx_stop     = (state_q == S_STOP);
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_transmitter_parity` instance between N byte requesters. Each requester offers a byte over a valid/ready handshake. The scheduler grants one requester at a time and latches its byte onto the transmitter's `din`. It then sequences the transmitter's active-low `start` and its `stop` inputs, timing the frame with an internal cycle counter because the transmitter has no done output. It sits between the command/log sources and the transmitter in the serial-out path.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `FRAME_CYCLES`, 11: clocks the transmitter needs per frame (start + 8 data + parity + stop, one bit per clock).
- `GAP_CYCLES`, 2: idle clocks enforced between frames (0 allowed).

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N  requester i has a byte to send.
- `req_data`  in  8*N  byte of requester i at bits [8i+7:8i].
- `req_ready`  out  N  one-hot accept strobe; a byte transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `tx_din`  out  8  byte to the transmitter `din`.
- `tx_start`  out  1  to the transmitter `start`; active-low, 1 = idle.
- `tx_stop`  out  1  to the transmitter `stop`; one-cycle high pulse that returns it to IDLE.
- `grant_id`  out  $clog2(N)  index of the requester currently or last served.
- `busy`  out  1  high in every state except IDLE.
- `frame_count`  out  16  number of frames completed; wraps at 0xFFFF→0.

## Operation
- States: IDLE, GRANT, SEND, STOP, GAP.
- IDLE:
  - If any `req_valid` bit is high, pick the winner and go to GRANT.
  - Winner = first requester with valid high, searching upward from `last+1`, modulo N.
  - `last` resets to N-1, so requester 0 has first priority after reset.
- GRANT (1 cycle): `req_ready[grant_id]`=1.
  - If `req_valid[grant_id]` is high, latch the byte into `tx_din`, set `last`=`grant_id`, go to SEND.
  - If it is low (the requester withdrew), transfer nothing, leave `last` unchanged, return to IDLE.
- SEND: `tx_start`=0 for exactly FRAME_CYCLES cycles, timed by a down-counter, then go to STOP.
- STOP (1 cycle):
  - `tx_start`=1, `tx_stop`=1, increment `frame_count`.
  - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- `tx_din` holds the latched byte from the end of GRANT until the next GRANT. It does not change while SEND or STOP is active.
- `req_ready` is 0 in every state except GRANT. At most one bit is ever high.
- `req_valid` changes outside GRANT are ignored. Requests raised during SEND, STOP or GAP wait for IDLE.
- Any requester that holds valid is guaranteed service within N frames (no starvation).

## Timing
- Reset values (asserted asynchronously while `rst`=0):
  - state IDLE
  - `tx_start`=1, `tx_stop`=0, `tx_din`=0
  - `req_ready`=0, `grant_id`=0, `busy`=0, `frame_count`=0
  - `last`=N-1, all counters 0
- Reset in mid-frame: all outputs go to their reset values immediately, so `tx_start` rises without a `tx_stop` pulse. The aborted frame is not counted.
- Request to ready: valid sampled high in IDLE at edge k → `req_ready` high in cycle k+1.
- `tx_start` falls at edge k+2 and stays low for FRAME_CYCLES cycles. `tx_stop` pulses in the following cycle.
- Frame period with continuous requests: FRAME_CYCLES + GAP_CYCLES + 3 clocks (IDLE + GRANT + SEND + STOP + GAP). This is 16 with the defaults.
- Simultaneous requests in IDLE: exactly one grant, chosen by round-robin order. There is no combinational path from `req_valid` to `req_ready`; all outputs are registered or decoded from state only.

## Test plan
- **Reset:** `rst`=0 with random inputs.
  - Required: `tx_start`=1, `tx_stop`=0, `tx_din`=0x00, `req_ready`=0, `busy`=0.
  - Release `rst` with no requests: state stays IDLE.
- **Single request:** requester 2 offers 0x81.
  - `req_ready`=4'b0100 for 1 cycle.
  - `tx_din`=0x81, then `tx_start` low for exactly 11 cycles.
  - `tx_stop` high for 1 cycle, `frame_count`=1, `busy` low 3 cycles after the `tx_stop` pulse.
- **All requesters held valid (0x10, 0x20, 0x30, 0x40):**
  - Grant order 0,1,2,3,0.
  - `tx_start` falling edges 16 cycles apart.
  - `tx_din` sequence 0x10, 0x20, 0x30, 0x40.
- **Round-robin fairness:** requesters 1 and 3 held valid after requester 3 was served last.
  - Next grant is 1, then 3, then 1.
- **Withdrawal and late arrival:**
  - Requester 0 drops valid during GRANT: no SEND, `frame_count` unchanged, IDLE on the next cycle.
  - A valid raised during SEND is not granted before `busy` falls.
- **Reset mid-frame and wrap:**
  - `rst` pulsed low 5 cycles into SEND: `tx_start`=1 immediately, `frame_count`=0.
  - `frame_count` forced to 0xFFFF then one frame sent: reads 0x0000.
